// File: rtl/p_instruction.sv
// Shared instruction-format definitions: kind enumeration, kind nibble constants
// and the encode/decode helpers used by both the encoder and the kind decoder.
package p_instruction;

  typedef enum logic [2:0] {
    KIND_RRR     = 3'd0,
    KIND_MEMORY  = 3'd1,
    KIND_MODEL   = 3'd2,
    KIND_RRI     = 3'd3,
    KIND_CUSTOM  = 3'd4,
    KIND_INVALID = 3'd5
  } e_kind;

  localparam logic [3:0] KIND_NIB_RRR    = 4'b0000;
  localparam logic [3:0] KIND_NIB_MEMORY = 4'b0001;
  localparam logic [3:0] KIND_NIB_MODEL  = 4'b0010;
  localparam logic [1:0] KIND_PFX_RRI    = 2'b01;
  localparam logic [1:0] KIND_PFX_CUSTOM = 2'b11;

  // Returns {valid, nibble}; sub only lands in the nibble for the prefixed kinds.
  function automatic logic [4:0] f_kind_nibble(input e_kind kind, input logic [1:0] sub);
    logic [4:0] r;
    case (kind)
      KIND_RRR:    r = {1'b1, KIND_NIB_RRR};
      KIND_MEMORY: r = {1'b1, KIND_NIB_MEMORY};
      KIND_MODEL:  r = {1'b1, KIND_NIB_MODEL};
      KIND_RRI:    r = {1'b1, KIND_PFX_RRI, sub};
      KIND_CUSTOM: r = {1'b1, KIND_PFX_CUSTOM, sub};
      default:     r = {1'b0, 4'b0000};
    endcase
    return r;
  endfunction

  // Decoder side, built on the same constants so the two cannot drift apart.
  function automatic e_kind f_nibble_kind(input logic [3:0] nib);
    e_kind k;
    if (nib == KIND_NIB_RRR) begin
      k = KIND_RRR;
    end else if (nib == KIND_NIB_MEMORY) begin
      k = KIND_MEMORY;
    end else if (nib == KIND_NIB_MODEL) begin
      k = KIND_MODEL;
    end else if (nib[3:2] == KIND_PFX_RRI) begin
      k = KIND_RRI;
    end else if (nib[3:2] == KIND_PFX_CUSTOM) begin
      k = KIND_CUSTOM;
    end else begin
      k = KIND_INVALID;
    end
    return k;
  endfunction

endpackage

// File: rtl/m_skid_buffer.sv
// Two-entry FIFO-ordered valid/ready buffer with registered in_ready and output;
// the head register keeps its last value when the buffer drains.
module m_skid_buffer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   count_r, count_s;
  logic [W-1:0] head_r, head_s, tail_r, tail_s;
  logic         in_ready_r, out_valid_r;
  logic         enq_s, deq_s;

  assign enq_s = in_valid & in_ready_r;
  assign deq_s = out_valid_r & out_ready;

  // Next occupancy and entry contents; the head slot is always the oldest word.
  always_comb begin
    count_s = count_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case (count_r)
      2'd0: begin
        if (enq_s) begin
          head_s  = in_data;
          count_s = 2'd1;
        end else begin
          count_s = 2'd0;
        end
      end
      2'd1: begin
        if (enq_s && deq_s) begin
          head_s = in_data;
        end else if (enq_s) begin
          tail_s  = in_data;
          count_s = 2'd2;
        end else if (deq_s) begin
          count_s = 2'd0;
        end else begin
          count_s = 2'd1;
        end
      end
      2'd2: begin
        if (deq_s) begin
          head_s  = tail_r;
          count_s = 2'd1;
        end else begin
          count_s = 2'd2;
        end
      end
      default: begin
        count_s = 2'd0;
      end
    endcase
  end

  // Buffer state and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= 2'd0;
      head_r      <= {W{1'b0}};
      tail_r      <= {W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_s;
      head_r      <= head_s;
      tail_r      <= tail_s;
      in_ready_r  <= (count_s != 2'd2);
      out_valid_r <= (count_s != 2'd0);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r;

endmodule

// File: rtl/m_encoder_kind.sv
// Packs (kind, sub, payload) into a 32-bit instruction word, drops unencodable
// kinds with an error pulse, and counts emitted and rejected words.
module m_encoder_kind
  import p_instruction::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  e_kind            in_kind,
  input  logic [1:0]       in_sub,
  input  logic [27:0]      in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_pulse,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]       nib_s;
  logic [31:0]      word_s;
  logic             accept_s, push_s, reject_s, pop_s;
  logic             err_pulse_r;
  logic [CNT_W-1:0] enc_count_r, err_count_r;

  assign nib_s    = f_kind_nibble(in_kind, in_sub);
  assign word_s   = {nib_s[3:0], in_payload};
  assign accept_s = in_valid & in_ready;
  assign push_s   = accept_s & nib_s[4];
  assign reject_s = accept_s & ~nib_s[4];
  assign pop_s    = out_valid & out_ready;

  m_skid_buffer #(.W(32)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (push_s),
    .in_ready  (in_ready),
    .in_data   (word_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_instr)
  );

  // Error pulse and saturating emit/reject counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_r <= 1'b0;
      enc_count_r <= {CNT_W{1'b0}};
      err_count_r <= {CNT_W{1'b0}};
    end else begin
      err_pulse_r <= reject_s;
      if (pop_s && (enc_count_r != CNT_MAX)) begin
        enc_count_r <= enc_count_r + CNT_ONE;
      end
      if (reject_s && (err_count_r != CNT_MAX)) begin
        err_count_r <= err_count_r + CNT_ONE;
      end
    end
  end

  assign err_pulse = err_pulse_r;
  assign enc_count = enc_count_r;
  assign err_count = err_count_r;

endmodule

// File: tb/tb_m_encoder_kind.sv
// Scoreboard bench for m_encoder_kind: drivers push expected words, a negedge
// monitor compares every output cycle against a queue-based reference model.
module tb_m_encoder_kind;
  import p_instruction::*;

  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  e_kind            in_kind = KIND_RRR;
  logic [1:0]       in_sub = 2'b00;
  logic [27:0]      in_payload = 28'h0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic             err_pulse;
  logic [CNT_W-1:0] enc_count, err_count;

  m_encoder_kind #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_sub(in_sub), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err_pulse(err_pulse), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          kind;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          fails = 0;
  int          enc_m = 0;
  int          err_m = 0;
  int          popped = 0;
  bit          err_pend = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [31:0] last_shown = 32'h0;

  // Reference encoding: kind number -> nibble value, -1 for unencodable.
  function automatic int nib_of(input int k, input int sub);
    case (k)
      0: return 0;
      1: return 1;
      2: return 2;
      3: return 4 + sub;
      4: return 12 + sub;
      default: return -1;
    endcase
  endfunction

  function automatic int kind_of(input int nib);
    if (nib == 0) return 0;
    if (nib == 1) return 1;
    if (nib == 2) return 2;
    if (nib / 4 == 1) return 3;
    if (nib / 4 == 3) return 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Monitor: compares every cycle against the model, pops on downstream handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("err_pulse", {31'b0, err_pulse}, {31'b0, err_pend});
      err_pend = 1'b0;
      chk("enc_count", 32'(enc_count), 32'(enc_m));
      chk("err_count", 32'(err_count), 32'(err_m));
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (out_valid && q.size() != 0) begin
        chk("out_instr", out_instr, q[0].word);
        chk("decoded_kind", kind_of(int'(out_instr[31:28])), q[0].kind);
        last_shown = out_instr;
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
          if (enc_m < SAT) enc_m++;
        end
      end else if (!out_valid) begin
        chk("out_instr_hold", out_instr, last_shown);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic model_accept(input int k, input int sub, input logic [27:0] pl);
    int nib;
    exp_t e;
    nib = nib_of(k, sub);
    if (nib >= 0) begin
      e.word = {nib[3:0], pl};
      e.kind = k;
      q.push_back(e);
    end else begin
      err_pend = 1'b1;
      if (err_m < SAT) err_m++;
    end
  endtask

  task automatic send(input int k, input int sub, input logic [27:0] pl);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    in_kind = e_kind'(k[2:0]);
    in_sub = sub[1:0];
    in_payload = pl;
    in_valid = 1'b1;
    while (!ok && n <= 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      @(posedge clk);
      model_accept(k, sub, pl);
    end else begin
      fail_now("accept_timeout");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_enc_count", 32'(enc_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    q.delete();
    enc_m = 0;
    err_m = 0;
    err_pend = 1'b0;
    last_shown = 32'h0;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int k, sub, base;
    logic [27:0] pl;
    logic [31:0] exp_words [5];
    int kinds [5];
    int subs [5];

    exp_words = '{32'h0123_4567, 32'h1123_4567, 32'h2123_4567, 32'h6123_4567, 32'hD123_4567};
    kinds     = '{0, 1, 2, 3, 4};
    subs      = '{0, 0, 0, 2, 1};

    out_ready = 1'b1;
    #2;
    chk("por_out_valid", {31'b0, out_valid}, 32'd0);
    chk("por_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("por_in_ready_release", {31'b0, in_ready}, 32'd1);

    // Directed encodings, each visible one cycle after acceptance.
    for (int i = 0; i < 5; i++) begin
      send(kinds[i], subs[i], 28'h123_4567);
      chk("enc_valid", {31'b0, out_valid}, 32'd1);
      chk("enc_word", out_instr, exp_words[i]);
    end

    // Invalid kind: dropped, one-cycle pulse, err_count 0 -> 1.
    send(5, 0, 28'hFFF_FFFF);
    chk("inv_pulse", {31'b0, err_pulse}, 32'd1);
    chk("inv_out_valid", {31'b0, out_valid}, 32'd0);
    chk("inv_err_count", 32'(err_count), 32'd1);
    @(posedge clk);
    #1;
    chk("inv_pulse_gone", {31'b0, err_pulse}, 32'd0);
    chk("inv_enc_count", 32'(enc_count), 32'd5);

    // Reset with two words buffered.
    out_ready = 1'b0;
    send(0, 0, 28'h0AA_0001);
    send(1, 0, 28'h0BB_0002);
    do_reset();

    // Backpressure: third word must wait for a dequeue.
    out_ready = 1'b0;
    send(0, 0, 28'h1);
    send(0, 0, 28'h2);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    fork
      send(0, 0, 28'h3);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_hold", out_instr, 32'h0000_0001);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_enc_count", 32'(enc_count), 32'd3);

    // Streaming: enqueue and dequeue every cycle for 100 words.
    base = popped;
    for (int i = 0; i < 100; i++) begin
      k = $urandom_range(0, 4);
      sub = $urandom_range(0, 3);
      pl = 28'($urandom);
      in_kind = e_kind'(k[2:0]);
      in_sub = sub[1:0];
      in_payload = pl;
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      model_accept(k, sub, pl);
      #1;
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", popped - base, 32'd100);

    // Random mix with random backpressure, including unlisted kind values.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send($urandom_range(0, 7), $urandom_range(0, 3), 28'($urandom));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Saturation at CNT_W=4.
    do_reset();
    for (int i = 0; i < 20; i++) send($urandom_range(0, 4), $urandom_range(0, 3), 28'($urandom));
    for (int i = 0; i < 20; i++) send($urandom_range(5, 7), $urandom_range(0, 3), 28'($urandom));
    drain();
    chk("sat_enc_count", 32'(enc_count), 32'h0000_000F);
    chk("sat_err_count", 32'(err_count), 32'h0000_000F);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
